// File: rtl/uart_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_deframer
// Description : Recovers START/STOP delimited, byte-stuffed frames of N_BYTES
//               payload from the uart_rx byte stream; valid/ready output with
//               saturating good-frame and error counters.
//               Optional trailing XOR checksum: UART_FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_frame_deframer #(
    parameter int         N_BYTES    = 4,
    parameter logic [7:0] START_BYTE = 8'h55,
    parameter logic [7:0] STOP_BYTE  = 8'hAA,
    parameter logic [7:0] ESC_BYTE   = 8'h7D,
    parameter logic [7:0] ESC_XOR    = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [8*N_BYTES-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [7:0]           frame_cnt,
    output logic [7:0]           err_cnt
);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam int c_FRAME_LEN = N_BYTES + 1;
`else
    localparam int c_FRAME_LEN = N_BYTES;
`endif
    localparam int                 c_IDX_W   = $clog2(c_FRAME_LEN + 1);
    localparam logic [c_IDX_W-1:0] c_LEN_IDX = c_IDX_W'(c_FRAME_LEN);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_ESCAPED = 2'd2;

    localparam logic [1:0] c_ERR_LEN = 2'd1;
    localparam logic [1:0] c_ERR_OVR = 2'd2;
    localparam logic [1:0] c_ERR_CKS = 2'd3;

    generate
        if ((START_BYTE == STOP_BYTE) || (START_BYTE == ESC_BYTE) ||
            (STOP_BYTE == ESC_BYTE)) begin : g_bad_delims
            $error("uart_frame_deframer: START/STOP/ESC bytes must be distinct");
        end
        if ((N_BYTES < 1) || (N_BYTES > 16)) begin : g_bad_len
            $error("uart_frame_deframer: N_BYTES must be 1..16");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_buf [c_FRAME_LEN];
    logic [8*N_BYTES-1:0] r_frame_data;
    logic                 r_frame_valid;
    logic                 r_err_pulse;
    logic [1:0]           r_err_code;
    logic [7:0]           r_frame_cnt;
    logic [7:0]           r_err_cnt;

    logic [1:0]           w_state_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [7:0]           w_byte;
    logic                 w_store;
    logic                 w_stop_ok;
    logic                 w_len_err;
    logic                 w_cksum_bad;
    logic                 w_overrun;
    logic                 w_load;
    logic                 w_err;
    logic [1:0]           w_err_code;
    logic [8*N_BYTES-1:0] w_payload;

    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_pack
            assign w_payload[8*gi +: 8] = r_buf[gi];
        end
    endgenerate

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] w_cksum;
    always_comb begin
        w_cksum = 8'h00;
        for (int i = 0; i < N_BYTES; i++) begin
            w_cksum = w_cksum ^ r_buf[i];
        end
    end
    // Last stored byte is the received checksum, never part of frame_data.
    assign w_cksum_bad = (w_cksum != r_buf[N_BYTES]);
`else
    assign w_cksum_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_store     = 1'b0;
        w_stop_ok   = 1'b0;
        w_len_err   = 1'b0;
        w_byte      = (r_state == c_ST_ESCAPED) ? (rx_data ^ ESC_XOR) : rx_data;
        if (rx_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_data == START_BYTE) begin
                        w_state_nxt = c_ST_PAYLOAD;
                        w_idx_nxt   = '0;
                    end
                end
                c_ST_PAYLOAD, c_ST_ESCAPED: begin
                    if (rx_data == START_BYTE) begin
                        w_state_nxt = c_ST_PAYLOAD;
                        w_idx_nxt   = '0;
                    end else if ((r_state == c_ST_PAYLOAD) && (rx_data == ESC_BYTE)) begin
                        w_state_nxt = c_ST_ESCAPED;
                    end else if ((r_state == c_ST_PAYLOAD) && (rx_data == STOP_BYTE)) begin
                        w_state_nxt = c_ST_IDLE;
                        if (r_idx == c_LEN_IDX) begin
                            w_stop_ok = 1'b1;
                        end else begin
                            w_len_err = 1'b1;
                        end
                    end else if (r_idx < c_LEN_IDX) begin
                        // Escaped STOP/ESC values land here as plain data.
                        w_store     = 1'b1;
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = c_ST_PAYLOAD;
                    end else begin
                        w_len_err   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_overrun = w_stop_ok && !w_cksum_bad && r_frame_valid && !frame_ready;
    assign w_load    = w_stop_ok && !w_cksum_bad && !w_overrun;
    assign w_err     = w_len_err || w_overrun || (w_stop_ok && w_cksum_bad);

    always_comb begin
        w_err_code = c_ERR_CKS;
        if (w_len_err) begin
            w_err_code = c_ERR_LEN;
        end else if (w_overrun) begin
            w_err_code = c_ERR_OVR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_idx         <= '0;
            for (int i = 0; i < c_FRAME_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_code    <= 2'd0;
            r_frame_cnt   <= 8'h00;
            r_err_cnt     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            for (int i = 0; i < c_FRAME_LEN; i++) begin
                if (w_store && (r_idx == c_IDX_W'(i))) begin
                    r_buf[i] <= w_byte;
                end
            end
            if (w_load) begin
                r_frame_data <= w_payload;
            end
            // A delivery in the accept cycle keeps valid high with fresh data.
            r_frame_valid <= w_load || (r_frame_valid && !frame_ready);
            r_err_pulse   <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if (w_load && (r_frame_cnt != 8'hFF)) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
